// File: rtl/ntt_pkg.sv
// Shared types for the NTT/INTT datapath: lane geometry, beat type and
// the 3-bit beat/lane index used by the 8x8 reordering blocks.
package ntt_pkg;

  localparam int LANES   = 8;
  localparam int COEFF_W = 16;

  typedef logic [2:0]               block_idx_t;
  typedef logic [COEFF_W-1:0]       coeff_t;
  typedef coeff_t [LANES-1:0]       lane_t;

  // Reverse the three index bits (0,4,2,6,1,5,3,7 sequence)
  function automatic block_idx_t bitrev3(input block_idx_t x);
    return {x[0], x[1], x[2]};
  endfunction

endpackage

// File: rtl/decomm_bank.sv
// One 8x8 coefficient bank for the decommutor. Rows are written a whole
// beat at a time; the read port returns one column (lane rd_col of every
// row), which is what performs the transpose.
module decomm_bank
  import ntt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  block_idx_t wr_row,
  input  lane_t      wr_data,
  input  block_idx_t rd_col,
  output lane_t      rd_data
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_row
    lane_t row_reg;

    // Capture the incoming beat into this row when it is the addressed row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        row_reg <= '0;
      end else if (we && (wr_row == block_idx_t'(gi))) begin
        row_reg <= wr_data;
      end
    end

    // Output lane gi comes from input beat gi, lane rd_col
    assign rd_data[gi] = row_reg[rd_col];
  end

endmodule

// File: rtl/ntt_decommutor.sv
// INTT output decommutor: gathers 8 beats x 8 lanes into one of two
// ping-pong banks and emits the transposed block, restoring natural
// coefficient order. valid/ready on both sides; ready_in depends only on
// registered flags so there is no ready_out -> ready_in path.
// Optional build macro DECOMM_BITREV_EN: read beats in bit-reversed order
// (0,4,2,6,1,5,3,7); handshake, latency and blk_done are unchanged.
module ntt_decommutor
  import ntt_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  valid_in,
  output logic  ready_in,
  input  lane_t lane_in,
  output logic  valid_out,
  input  logic  ready_out,
  output lane_t lane_out,
  output logic  blk_done
);

  logic [1:0]  full_reg;
  logic        wr_bank_reg;
  logic        rd_bank_reg;
  block_idx_t  wr_cnt_reg;
  block_idx_t  rd_cnt_reg;

  logic        wr_fire;
  logic        rd_fire;
  block_idx_t  rd_col;
  lane_t       bank_rd [2];

  assign ready_in  = !full_reg[wr_bank_reg];
  assign valid_out = full_reg[rd_bank_reg];

  // clear wins: the beat presented alongside it is neither stored nor read
  assign wr_fire = valid_in  && ready_in  && !clear;
  assign rd_fire = valid_out && ready_out && !clear;

  assign blk_done = rd_fire && (rd_cnt_reg == 3'd7);

`ifdef DECOMM_BITREV_EN
  assign rd_col = bitrev3(rd_cnt_reg);
`else
  assign rd_col = rd_cnt_reg;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    decomm_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_fire && (wr_bank_reg == 1'(gi))),
      .wr_row  (wr_cnt_reg),
      .wr_data (lane_in),
      .rd_col  (rd_col),
      .rd_data (bank_rd[gi])
    );
  end

  assign lane_out = bank_rd[rd_bank_reg];

  // Bank ownership: write side fills a bank and marks it full, read side
  // drains it and releases it. They never touch the same flag in one cycle
  // because the write bank is never full and the read bank always is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg    <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
    end else if (clear) begin
      full_reg    <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt_reg <= wr_cnt_reg + 3'd1;
        if (wr_cnt_reg == 3'd7) begin
          full_reg[wr_bank_reg] <= 1'b1;
          wr_bank_reg           <= ~wr_bank_reg;
        end
      end
      if (rd_fire) begin
        rd_cnt_reg <= rd_cnt_reg + 3'd1;
        if (rd_cnt_reg == 3'd7) begin
          full_reg[rd_bank_reg] <= 1'b0;
          rd_bank_reg           <= ~rd_bank_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_decommutor.sv
// Directed bench for ntt_decommutor with a scoreboard: when the 8th beat of
// a block is accepted, the 8 expected (transposed) output beats are queued;
// they are compared as the DUT presents and hands off output beats.
module tb_ntt_decommutor;
  import ntt_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  clear;
  logic  valid_in;
  logic  ready_in;
  lane_t lane_in;
  logic  valid_out;
  logic  ready_out;
  lane_t lane_out;
  logic  blk_done;

  int checks = 0;
  int errors = 0;

  lane_t exp_q[$];
  lane_t blk_mem [8];
  int    in_cnt = 0;
  int    blk_no = 0;

  always #5 clk = ~clk;

  ntt_decommutor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .lane_in   (lane_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .lane_out  (lane_out),
    .blk_done  (blk_done)
  );

  task automatic chk(input string tag, input logic [LANES*COEFF_W-1:0] obs,
                     input logic [LANES*COEFF_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input beat b, lane l of block n carries 64n + 8b + l
  function automatic lane_t gen_beat(input int blk, input int beat);
    lane_t v;
    for (int l = 0; l < LANES; l++) v[l] = coeff_t'(64 * blk + 8 * beat + l);
    return v;
  endfunction

  // Which input lane feeds output beat k
  function automatic int read_col(input int k);
`ifdef DECOMM_BITREV_EN
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
    return k;
`endif
  endfunction

  task automatic push_block();
    lane_t e;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < LANES; i++) e[i] = blk_mem[i][read_col(k)];
      exp_q.push_back(e);
    end
  endtask

  // One clock: compare outputs at the falling edge, update the model with
  // the handshakes that the next rising edge will complete.
  task automatic tick();
    int pend;
    bit fire_in;
    bit fire_out;
    @(negedge clk);
    pend = (exp_q.size() + 7) / 8;
    chk("valid_out", valid_out, exp_q.size() != 0);
    chk("ready_in", ready_in, pend < 2);
    fire_out = (exp_q.size() != 0) && ready_out && !clear;
    chk("blk_done", blk_done, fire_out && (exp_q.size() % 8 == 1));
    if (exp_q.size() != 0) chk("lane_out", lane_out, exp_q[0]);
    if (fire_out) void'(exp_q.pop_front());
    fire_in = valid_in && (pend < 2) && !clear;
    if (fire_in) begin
      blk_mem[in_cnt] = lane_in;
      in_cnt++;
      if (in_cnt == 8) begin
        push_block();
        in_cnt = 0;
        blk_no++;
      end
    end
    if (clear) begin
      exp_q.delete();
      in_cnt = 0;
      blk_no++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic vin, input logic rout);
    for (int c = 0; c < n; c++) begin
      valid_in  = vin;
      ready_out = rout;
      lane_in   = gen_beat(blk_no, in_cnt);
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, valid_out, 1'b0);
    chk({tag, "_lane_out"}, lane_out, '0);
    chk({tag, "_ready_in"}, ready_in, 1'b1);
    chk({tag, "_blk_done"}, blk_done, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    lane_in   = '0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single block, ready_out high
    run(8, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);

    // Four blocks back to back with valid_in held high
    run(32, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);

    // Downstream stalled: two banks fill, then drain
    run(20, 1'b1, 1'b0);
    run(18, 1'b0, 1'b1);

    // Both banks full while draining the last beat of one
    run(16, 1'b1, 1'b0);
    run(12, 1'b1, 1'b1);
    run(20, 1'b0, 1'b1);

    // clear after 5 beats of a block, beat presented with clear is dropped
    run(5, 1'b1, 1'b1);
    clear = 1'b1;
    run(1, 1'b1, 1'b1);
    clear = 1'b0;
    run(8, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);

    // clear while a full block is waiting downstream
    run(8, 1'b1, 1'b0);
    clear = 1'b1;
    run(1, 1'b0, 1'b0);
    clear = 1'b0;
    run(3, 1'b0, 1'b1);

    // Async reset while beat 3 of a block is being drained
    run(8, 1'b1, 1'b0);
    run(3, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    exp_q.delete();
    in_cnt = 0;
    blk_no++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(8, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
